jtframe_dual_ram_clr: RTL and testbench

JTFRAME_DUAL_RAM_CLR -- requirements
Module: jtframe_dual_ram_clr

---
 rtl/jtframe_dual_ram_clr.sv | 116 +++++++++++
 tb/tb_jtframe_dual_ram_clr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/jtframe_dual_ram_clr.sv
// Dual-port byte-writable RAM with a built-in clear sequencer that fills every
// word with FILL after reset or on request; reads use a LATENCY-deep pipeline.
module jtframe_dual_ram_clr #(
    parameter int          DW         = 16,
    parameter int          AW         = 10,
    parameter int          LATENCY    = 1,
    parameter bit          FORWARD    = 1'b0,
    parameter logic [DW-1:0] FILL     = '0,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            busy,
    input  logic            cen0,
    input  logic            cen1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   data0,
    input  logic [DW-1:0]   data1,
    input  logic [DW/8-1:0] we0,
    input  logic [DW/8-1:0] we1,
    output logic [DW-1:0]   q0,
    output logic [DW-1:0]   q1
);
    localparam int BW = DW / 8;

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("jtframe_dual_ram_clr: LATENCY must be 1 or 2");
    end

    typedef enum logic { IDLE, CLEAR } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic [DW-1:0]   pipe0_q [LATENCY];
    logic [DW-1:0]   pipe1_q [LATENCY];
    logic [DW-1:0]   rd0, rd1;
    logic            wr0, wr1, fill_we;

    assign busy    = (state_q == CLEAR);
    assign fill_we = busy && !rst;
    assign wr0     = cen0 && !busy && !rst;
    assign wr1     = cen1 && !busy && !rst;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == {AW{1'b1}}) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ON_RST ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the storage array has no reset; only the clear sequencer changes its contents.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt_q] <= FILL;
        end else begin
            // Port 0 is assigned last so it wins any lane both ports write.
            for (int b = 0; b < BW; b++) begin
                if (wr1 && we1[b]) mem[addr1][8*b +: 8] <= data1[8*b +: 8];
                if (wr0 && we0[b]) mem[addr0][8*b +: 8] <= data0[8*b +: 8];
            end
        end
    end

    // Read-first words, optionally merged with the other port's same-cycle write.
    always_comb begin
        rd0 = mem[addr0];
        rd1 = mem[addr1];
        if (FORWARD && addr0 == addr1) begin
            for (int b = 0; b < BW; b++) begin
                if (wr1 && we1[b]) rd0[8*b +: 8] = data1[8*b +: 8];
                if (wr0 && we0[b]) rd1[8*b +: 8] = data0[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe0_q[i] <= '0;
                pipe1_q[i] <= '0;
            end
        end else begin
            if (cen0) begin
                pipe0_q[0] <= rd0;
                for (int i = 1; i < LATENCY; i++) pipe0_q[i] <= pipe0_q[i-1];
            end
            if (cen1) begin
                pipe1_q[0] <= rd1;
                for (int i = 1; i < LATENCY; i++) pipe1_q[i] <= pipe1_q[i-1];
            end
        end
    end

    assign q0 = busy ? '0 : pipe0_q[LATENCY-1];
    assign q1 = busy ? '0 : pipe1_q[LATENCY-1];

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Directed bench: three instances (latency 2 / forward 0, latency 2 / forward 1,
// latency 1 / forward 0) share one stimulus stream with hand-computed results.
module tb_jtframe_dual_ram_clr;
    logic        clk = 1'b0;
    logic        rst, clr, cen0, cen1;
    logic [3:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic [1:0]  we0, we1;
    logic        busy_a, busy_b, busy_c;
    logic [15:0] q0_a, q1_a, q0_b, q1_b, q0_c, q1_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jtframe_dual_ram_clr #(.DW(16), .AW(4), .LATENCY(2), .FORWARD(1'b0), .FILL(16'hA5A5), .CLR_ON_RST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a), .cen0(cen0), .cen1(cen1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .we0(we0), .we1(we1), .q0(q0_a), .q1(q1_a));

    jtframe_dual_ram_clr #(.DW(16), .AW(4), .LATENCY(2), .FORWARD(1'b1), .FILL(16'hA5A5), .CLR_ON_RST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b), .cen0(cen0), .cen1(cen1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .we0(we0), .we1(we1), .q0(q0_b), .q1(q1_b));

    jtframe_dual_ram_clr #(.DW(16), .AW(4), .LATENCY(1), .FORWARD(1'b0), .FILL(16'hA5A5), .CLR_ON_RST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_c), .cen0(cen0), .cen1(cen1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .we0(we0), .we1(we1), .q0(q0_c), .q1(q1_c));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency-1 result after the first edge, latency-2 results after the second.
    task automatic rd(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [15:0] e0, input logic [15:0] e1);
        addr0 = a0; addr1 = a1; cen0 = 1'b1; cen1 = 1'b1; we0 = '0; we1 = '0;
        tick();
        check({tag, " c.q0"}, q0_c, e0);
        check({tag, " c.q1"}, q1_c, e1);
        tick();
        check({tag, " a.q0"}, q0_a, e0);
        check({tag, " a.q1"}, q1_a, e1);
        check({tag, " b.q0"}, q0_b, e0);
        check({tag, " b.q1"}, q1_b, e1);
    endtask

    task automatic count_busy(input string tag, input bit write_zero);
        int n = 0;
        while (busy_a && n < 64) begin
            if (write_zero) begin
                addr0 = 4'd0; addr1 = 4'd0; data0 = 16'h0000; data1 = 16'h0000;
                cen0 = 1'b1; cen1 = 1'b1; we0 = 2'b11; we1 = 2'b11;
            end
            tick();
            if (busy_a) begin
                check({tag, " q0 busy"}, q0_a, 16'h0000);
                check({tag, " q1 busy"}, q1_c, 16'h0000);
            end
            n++;
        end
        we0 = '0; we1 = '0;
        check({tag, " busy cycles"}, 16'(n), 16'd16);
        check({tag, " busy_c low"}, {15'b0, busy_c}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; cen0 = 1'b0; cen1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; we0 = '0; we1 = '0;
        repeat (3) tick();
        check("rst busy", {15'b0, busy_a}, 16'h0001);
        check("rst q0", q0_a, 16'h0000);
        check("rst q1", q1_c, 16'h0000);

        // Power-up clear: 16 busy cycles, then every word reads as the fill value.
        rst = 1'b0;
        count_busy("init", 1'b0);
        for (int i = 0; i < 16; i++)
            rd($sformatf("fill[%0d]", i), 4'(i), 4'(15 - i), 16'hA5A5, 16'hA5A5);

        // Low-byte write, then a cross-port read at latency 1 and 2.
        addr0 = 4'd3; data0 = 16'h1234; we0 = 2'b01; cen0 = 1'b1; cen1 = 1'b0;
        tick();
        we0 = '0; cen0 = 1'b0; addr1 = 4'd3; cen1 = 1'b1;
        tick();
        check("lat1 q1", q1_c, 16'hA534);
        check("lat2 early q1", q1_a, 16'hA5A5);
        tick();
        check("lat2 a.q1", q1_a, 16'hA534);
        check("lat2 b.q1", q1_b, 16'hA534);

        // Same-port read during write returns the old word.
        addr0 = 4'd3; data0 = 16'hFFFF; we0 = 2'b11; cen0 = 1'b1; cen1 = 1'b0;
        tick();
        check("rfirst c.q0", q0_c, 16'hA534);
        we0 = '0;
        tick();
        check("rfirst new c.q0", q0_c, 16'hFFFF);
        check("rfirst a.q0", q0_a, 16'hA534);

        // Same-address collision: port 0 owns its lanes, port 1 fills the rest.
        addr0 = 4'd5; addr1 = 4'd5; data0 = 16'h1111; data1 = 16'h2222;
        we0 = 2'b10; we1 = 2'b11; cen0 = 1'b1; cen1 = 1'b1;
        tick();
        rd("collide", 4'd5, 4'd5, 16'h1122, 16'h1122);

        // Cross-port forwarding.
        addr0 = 4'd7; data0 = 16'hBEEF; we0 = 2'b11; cen0 = 1'b1;
        addr1 = 4'd7; we1 = 2'b00; cen1 = 1'b1;
        tick();
        check("fwd0 c.q1", q1_c, 16'hA5A5);
        we0 = '0; cen0 = 1'b0;
        tick();
        check("fwd0 a.q1", q1_a, 16'hA5A5);
        check("fwd1 b.q1", q1_b, 16'hBEEF);
        check("fwd after c.q1", q1_c, 16'hBEEF);

        // Disabled port neither writes nor moves its output.
        rd("pre-hold", 4'd7, 4'd7, 16'hBEEF, 16'hBEEF);
        addr0 = 4'd2; data0 = 16'h0000; we0 = 2'b11; cen0 = 1'b0; cen1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold a.q0 %0d", i), q0_a, 16'hBEEF);
            check($sformatf("hold c.q0 %0d", i), q0_c, 16'hBEEF);
        end
        rd("hold nowrite", 4'd2, 4'd2, 16'hA5A5, 16'hA5A5);

        // clr, restart at cnt=9, then reset mid-clear; writes during busy are dropped.
        cen0 = 1'b0; cen1 = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr busy", {15'b0, busy_a}, 16'h0001);
        addr0 = 4'd3; data0 = 16'h0000; we0 = 2'b11; cen0 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("clr q0 %0d", i), q0_c, 16'h0000);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        check("restart busy", {15'b0, busy_b}, 16'h0001);
        rst = 1'b1;
        repeat (2) tick();
        check("midrst busy", {15'b0, busy_a}, 16'h0001);
        check("midrst q1", q1_b, 16'h0000);
        rst = 1'b0;
        count_busy("midrst", 1'b1);
        check("flush a.q0", q0_a, 16'h0000);
        check("flush c.q0", q0_c, 16'h0000);
        rd("lost write", 4'd0, 4'd0, 16'hA5A5, 16'hA5A5);
        rd("refill", 4'd3, 4'd5, 16'hA5A5, 16'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
